// File: rtl/gray6_pkg.sv
// Shared definitions for the six-slot Gray-code polling arbiter:
// pointer sequence, code/index helpers and the arbiter FSM states.
package gray6_pkg;

  localparam int NUM_SLOTS = 6;

  // Marks a Gray code that is not part of the six-step cycle (101, 111)
  localparam logic [2:0] IDX_BAD = 3'd7;

  localparam logic [2:0] GRAY6_SEQ [0:5] = '{
    3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  function automatic logic [2:0] gray2idx(input logic [2:0] g);
    logic [2:0] idx;
    idx = IDX_BAD;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (g == GRAY6_SEQ[i]) idx = 3'(i);
    return idx;
  endfunction

  function automatic logic [2:0] nextgray(input logic [2:0] g);
    logic [2:0] nxt;
    nxt = 3'b000;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (g == GRAY6_SEQ[i]) nxt = GRAY6_SEQ[(i + 1) % NUM_SLOTS];
    return nxt;
  endfunction

endpackage

// File: rtl/gray6_step_counter.sv
// Mod-6 Gray-code poll pointer built from three T flip-flops. Steps once per
// enabled cycle; an illegal code (101/111) is cleared to 000 on the next edge.
module gray6_step_counter
  import gray6_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [2:0] ptr_gray
);

  logic [2:0] ptr_q, ptr_d;
  logic [2:0] tgl;

  // Toggle mask: bits that differ from the target code. Recovery toggles
  // every set bit, which lands on 000 without depending on en.
  always_comb begin
    tgl = 3'b000;
    if (gray2idx(ptr_q) == IDX_BAD) tgl = ptr_q;
    else if (en)                    tgl = ptr_q ^ nextgray(ptr_q);
    ptr_d = ptr_q ^ tgl;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= 3'b000;
    else        ptr_q <= ptr_d;
  end

  assign ptr_gray = ptr_q;

endmodule

// File: rtl/gray6_poll_arbiter.sv
// Round-robin polling arbiter for six requesters. A Gray-code pointer scans
// one slot per cycle; a grant is held until the request drops or HOLD_MAX.
module gray6_poll_arbiter
  import gray6_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int HCNT_W   = $clog2(HOLD_MAX) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SLOTS-1:0] req,
  output logic [NUM_SLOTS-1:0] gnt,
  output logic [2:0]           gnt_id,
  output logic [2:0]           ptr_gray,
  output logic                 busy,
  output logic                 timeout
);

  arb_state_e           state_q, state_d;
  logic [NUM_SLOTS-1:0] gnt_q, gnt_d;
  logic [2:0]           gnt_id_q, gnt_id_d;
  logic                 timeout_q, timeout_d;
  logic [HCNT_W-1:0]    hold_cnt_q, hold_cnt_d;

  logic                 step_en;
  logic [2:0]           cur_idx;
  logic [NUM_SLOTS-1:0] slot_oh;
  logic                 hit;
  logic                 held;

  gray6_step_counter u_ctr (
    .clk      (clk),
    .reset    (reset),
    .en       (step_en),
    .ptr_gray (ptr_gray)
  );

  // An illegal pointer code selects no slot, so it can never produce a grant
  assign cur_idx = gray2idx(ptr_gray);
  assign slot_oh = (cur_idx == IDX_BAD) ? '0 : (NUM_SLOTS'(1) << cur_idx);
  assign hit     = |(req & slot_oh);
  assign held    = |(req & gnt_q);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    step_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (hit) begin
          state_d    = ST_GRANT;
          gnt_d      = slot_oh;
          gnt_id_d   = cur_idx;
          hold_cnt_d = '0;
        end else if (|req) begin
          step_en = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        // A dropped request wins over expiry: that is a normal release
        if (!held) begin
          state_d  = ST_RELEASE;
          gnt_d    = '0;
          gnt_id_d = 3'd0;
        end else if (hold_cnt_q == HCNT_W'(HOLD_MAX - 1)) begin
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          gnt_id_d  = 3'd0;
          timeout_d = 1'b1;
        end
      end
      ST_RELEASE: begin
        // Stepping past the served slot keeps it from winning back-to-back
        step_en    = 1'b1;
        hold_cnt_d = '0;
        state_d    = ST_SCAN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= 3'd0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign timeout = timeout_q;
  assign busy    = (state_q == ST_GRANT);

endmodule

// File: tb/tb_gray6_poll_arbiter.sv
// Scoreboard bench for gray6_poll_arbiter: expected grants are queued as
// stimulus is applied and retired by a monitor watching gnt edges.
module tb_gray6_poll_arbiter;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] req = 6'b0;
  logic [5:0] gnt;
  logic [2:0] gnt_id;
  logic [2:0] ptr_gray;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int id;
    int len;
    int to;
  } gexp_t;

  gexp_t exp_q[$];

  gray6_poll_arbiter #(.HOLD_MAX(HM)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .ptr_gray (ptr_gray),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic push(input int id, input int len, input int to);
    gexp_t e;
    e.id = id; e.len = len; e.to = to;
    exp_q.push_back(e);
  endtask

  // Monitor: samples 1 time unit after each edge, stimulus moves at 2
  initial begin
    logic [5:0] prev;
    int len, cur_id, last_id;
    gexp_t e;
    prev = '0; len = 0; cur_id = -1; last_id = -1;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        prev = '0; len = 0; last_id = -1;
      end else begin
        if (prev == 6'b0 && gnt != 6'b0) begin
          chk("sb_rise_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            chk("gnt_id", int'(gnt_id), exp_q[0].id);
            chk("gnt_onehot", int'(gnt), int'(6'b000001 << exp_q[0].id));
          end
          chk("busy_hi", int'(busy), 1);
          chk("rr_repeat", int'(int'(gnt_id) == last_id && (req & ~gnt) != 6'b0), 0);
          cur_id = int'(gnt_id);
          len = 1;
        end else if (prev != 6'b0 && gnt == 6'b0) begin
          chk("sb_fall_nonempty", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("gnt_len", len, e.len);
            chk("timeout", int'(timeout), e.to);
          end
          chk("busy_lo", int'(busy), 0);
          chk("gid_zero", int'(gnt_id), 0);
          last_id = cur_id;
        end else begin
          if (gnt != 6'b0) len++;
          chk("to_quiet", int'(timeout), 0);
        end
        prev = gnt;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // 1: reset state, pointer frozen while idle
    tick();
    chk("rst_ptr", int'(ptr_gray), 0);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_gid", int'(gnt_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_to", int'(timeout), 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ptr", int'(ptr_gray), 0);
    end
    chk("idle_busy", int'(busy), 0);

    // 2: slot 2 from ptr 000, two scan steps then grant; drop -> release
    req = 6'b000100;
    push(2, 1, 0);
    tick(); chk("t2_ptr0", int'(ptr_gray), 3'b000);
    tick(); chk("t2_ptr1", int'(ptr_gray), 3'b001);
    tick(); chk("t2_ptr2", int'(ptr_gray), 3'b011);
    tick();
    chk("t2_gnt", int'(gnt), 6'b000100);
    chk("t2_gid", int'(gnt_id), 2);
    chk("t2_busy", int'(busy), 1);
    req = 6'b0;
    tick(); chk("t2_drop", int'(gnt), 0);
    tick(); chk("t2_ptr_rel", int'(ptr_gray), 3'b010);
    tick();

    // 3: all slots requesting, each grant cut by HOLD_MAX in rotation
    do_reset();
    for (int i = 0; i < 7; i++) push(i % 6, HM, 1);
    req = 6'b111111;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    chk("t3_drain", exp_q.size(), 0);
    req = 6'b0;
    tick();
    tick();
    chk("t3_ptr", int'(ptr_gray), 3'b001);
    chk("t3_busy", int'(busy), 0);

    // 4: illegal pointer code recovers to 000 with no grant
    force dut.u_ctr.ptr_q = 3'b101;
    tick();
    release dut.u_ctr.ptr_q;
    tick();
    chk("t4_ptr", int'(ptr_gray), 3'b000);
    chk("t4_gnt", int'(gnt), 0);
    chk("t4_busy", int'(busy), 0);

    // 5: reset during grant of slot 3, then slot 3 again after 3 steps
    do_reset();
    req = 6'b001000;
    push(3, 0, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); cnt++;
      if (gnt != 6'b0) break;
    end
    chk("t5_lat_a", cnt, 5);
    tick();
    reset = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    #1;
    chk("t5_rst_gnt", int'(gnt), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_ptr", int'(ptr_gray), 0);
    tick();
    reset = 1'b1;
    push(3, 1, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); cnt++;
      if (gnt != 6'b0) break;
    end
    chk("t5_lat_b", cnt, 5);
    chk("t5_gid", int'(gnt_id), 3);
    req = 6'b0;
    tick(); tick(); tick();

    // 6: request drops on the expiry cycle -> normal release, no timeout
    do_reset();
    req = 6'b000001;
    push(0, HM, 0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gnt != 6'b0) break;
    end
    chk("t6_gnt", int'(gnt), 6'b000001);
    repeat (HM - 1) tick();
    req = 6'b0;
    tick(); tick(); tick();

    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
